uart_reg_bridge: RTL and testbench
==================================

UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1_000_000, SHALL set the inter-byte timeout in clk cycles (minimum 2).
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock; all logic on its rising edge.
- nrst_in  in  1  reset; asynchronous assert, active-low.
- rx_data_in  in  8  received byte, valid when rx_rdy_in=1.
- rx_rdy_in  in  1  one-cycle pulse, one byte per pulse.
- tx_data_out  out  8  byte to transmit.
- tx_rdy_out  out  1  one-cycle pulse requesting transmission of tx_data_out.
- tx_done_in  in  1  one-cycle pulse when the transmitter finishes a byte.
- reg_addr_out  out  8  register address.
- reg_wdata_out  out  8  write data.
- reg_we_out  out  1  one-cycle write strobe.
- reg_re_out  out  1  one-cycle read strobe.
- reg_rdata_in  in  8  read data, valid exactly 1 cycle after reg_re_out.
- err_count_out  out  8  saturating protocol-error counter.
- busy_out  out  1  high whenever the state is not IDLE.

Function
REQ-003 States SHALL be IDLE, GET_ADDR, GET_DATA, WRITE, READ, CAPTURE, SEND, WAIT_TX.
REQ-004 In IDLE, rx byte 0x57 ('W') SHALL go to GET_ADDR with the write flag set; 0x52 ('R') SHALL go to GET_ADDR with the write flag clear; any other byte SHALL stay in IDLE and increment err_count_out.
REQ-005 In GET_ADDR, an rx byte SHALL be latched into reg_addr_out; next state SHALL be GET_DATA if writing, else READ.
REQ-006 In GET_DATA, an rx byte SHALL be latched into reg_wdata_out; next state SHALL be WRITE.
REQ-007 WRITE SHALL assert reg_we_out for exactly one cycle, then go to SEND if BRIDGE_ACK_EN is defined, else to IDLE.
REQ-008 READ SHALL assert reg_re_out for exactly one cycle; CAPTURE, on the following cycle, SHALL latch reg_rdata_in into tx_data_out and go to SEND.
REQ-009 SEND SHALL pulse tx_rdy_out for exactly one cycle with tx_data_out stable, then go to WAIT_TX.
REQ-010 WAIT_TX SHALL hold tx_data_out and go to IDLE on the tx_done_in pulse; tx_done_in in any other state SHALL be ignored.
REQ-011 In GET_ADDR and GET_DATA, a 32-bit counter SHALL reset on each state entry; after TIMEOUT_CYCLES cycles with no rx_rdy_in, the frame SHALL abort to IDLE and err_count_out SHALL increment.
REQ-012 rx_rdy_in in WRITE, READ, CAPTURE, SEND or WAIT_TX SHALL drop the byte and increment err_count_out.
REQ-013 A timeout and an rx_rdy_in in the same cycle SHALL count as byte reception, not a timeout.
REQ-014 err_count_out SHALL saturate at 0xFF and never wrap.
REQ-015 Worst-case latency: rx_rdy_in of the address byte of a read SHALL lead to tx_rdy_out exactly 4 cycles later (READ, CAPTURE, SEND).
REQ-016 reg_addr_out and reg_wdata_out SHALL hold their last latched values between frames.

Reset
REQ-017 While nrst_in=0, the state SHALL be IDLE and all outputs 0, including err_count_out, tx_data_out, reg_addr_out, reg_wdata_out and the timeout counter.
REQ-018 Reset asserted mid-frame or mid-transmission SHALL abandon the frame with no strobe emitted; the next frame after release SHALL be parsed normally.

Configuration
REQ-019 Macro BRIDGE_ACK_EN defined: each completed write SHALL transmit one ack byte 0x06 via SEND/WAIT_TX; undefined: writes SHALL return to IDLE silently and the write path SHALL contain no tx logic.

Verification
REQ-020 Bytes 0x57,0x10,0xA5 -> one reg_we_out pulse with addr 0x10, wdata 0xA5; with BRIDGE_ACK_EN, one tx_rdy_out with tx_data_out=0x06; without it, no tx_rdy_out.
REQ-021 Bytes 0x52,0x22 with reg_rdata_in=0x3C one cycle after reg_re_out -> tx_rdy_out 4 cycles after the address pulse, tx_data_out=0x3C, IDLE after tx_done_in.
REQ-022 Byte 0x41 in IDLE -> no strobes, err_count_out=1; 300 invalid bytes -> err_count_out=0xFF.
REQ-023 TIMEOUT_CYCLES=16, byte 0x57 then silence for 16 cycles -> IDLE, err_count_out+1; byte 0x10 on the 16th cycle -> accepted, GET_DATA.
REQ-024 Byte sent during WAIT_TX -> dropped, err_count_out+1, tx_data_out unchanged.
REQ-025 nrst_in low for 1 cycle during GET_DATA -> all outputs 0, no reg_we_out; a following valid write frame succeeds.

Source files
------------

// File: rtl/uart_reg_bridge.sv
// UART byte stream to register bus bridge: 'W' addr data writes, 'R' addr reads and returns the byte.
// Define BRIDGE_ACK_EN to make every completed write transmit an ack byte 0x06.
module uart_reg_bridge #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       nrst_in,
    input  logic [7:0] rx_data_in,
    input  logic       rx_rdy_in,
    output logic [7:0] tx_data_out,
    output logic       tx_rdy_out,
    input  logic       tx_done_in,
    output logic [7:0] reg_addr_out,
    output logic [7:0] reg_wdata_out,
    output logic       reg_we_out,
    output logic       reg_re_out,
    input  logic [7:0] reg_rdata_in,
    output logic [7:0] err_count_out,
    output logic       busy_out
);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, WRITE, READ, CAPTURE, SEND, WAIT_TX
    } state_t;

    localparam logic [7:0]  CMD_WRITE    = 8'h57;
    localparam logic [7:0]  CMD_READ     = 8'h52;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        write_flag;
    logic [31:0] timer;
    logic        timed_out;
    logic        err_event;

    assign timed_out = (timer == TIMEOUT_LAST);
    assign busy_out  = (state != IDLE);

    // A byte arriving on the timeout cycle wins, so timeouts only count when rx is quiet.
    always_comb begin
        err_event = 1'b0;
        case (state)
            IDLE:     err_event = rx_rdy_in && (rx_data_in != CMD_WRITE) && (rx_data_in != CMD_READ);
            GET_ADDR,
            GET_DATA: err_event = !rx_rdy_in && timed_out;
            default:  err_event = rx_rdy_in;
        endcase
    end

    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            state         <= IDLE;
            write_flag    <= 1'b0;
            timer         <= 32'd0;
            tx_data_out   <= 8'h00;
            tx_rdy_out    <= 1'b0;
            reg_addr_out  <= 8'h00;
            reg_wdata_out <= 8'h00;
            reg_we_out    <= 1'b0;
            reg_re_out    <= 1'b0;
            err_count_out <= 8'h00;
        end else begin
            reg_we_out <= 1'b0;
            reg_re_out <= 1'b0;
            tx_rdy_out <= 1'b0;

            if (err_event && (err_count_out != 8'hFF))
                err_count_out <= err_count_out + 8'd1;

            // Strobes are raised on the transition so they coincide with their state,
            // except tx_rdy_out which trails SEND by one cycle to give the 4-cycle read latency.
            case (state)
                IDLE: begin
                    if (rx_rdy_in && rx_data_in == CMD_WRITE) begin
                        write_flag <= 1'b1;
                        timer      <= 32'd0;
                        state      <= GET_ADDR;
                    end else if (rx_rdy_in && rx_data_in == CMD_READ) begin
                        write_flag <= 1'b0;
                        timer      <= 32'd0;
                        state      <= GET_ADDR;
                    end
                end
                GET_ADDR: begin
                    if (rx_rdy_in) begin
                        reg_addr_out <= rx_data_in;
                        timer        <= 32'd0;
                        if (write_flag) begin
                            state <= GET_DATA;
                        end else begin
                            reg_re_out <= 1'b1;
                            state      <= READ;
                        end
                    end else if (timed_out) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                GET_DATA: begin
                    if (rx_rdy_in) begin
                        reg_wdata_out <= rx_data_in;
                        reg_we_out    <= 1'b1;
                        state         <= WRITE;
                    end else if (timed_out) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                WRITE: begin
`ifdef BRIDGE_ACK_EN
                    tx_data_out <= 8'h06;
                    state       <= SEND;
`else
                    state <= IDLE;
`endif
                end
                READ:    state <= CAPTURE;
                CAPTURE: begin
                    tx_data_out <= reg_rdata_in;
                    state       <= SEND;
                end
                SEND: begin
                    tx_rdy_out <= 1'b1;
                    state      <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done_in)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: frame-level model pushes expected bus/tx events,
// a negedge monitor pops them as the DUT strobes. Honours BRIDGE_ACK_EN like the design.
module tb_uart_reg_bridge;

    localparam logic [7:0] KIND_WR = 8'd1;
    localparam logic [7:0] KIND_RD = 8'd2;
    localparam logic [7:0] KIND_TX = 8'd3;

    logic       clk = 1'b0;
    logic       nrst_in;
    logic [7:0] rx_data_in;
    logic       rx_rdy_in;
    logic [7:0] tx_data_out;
    logic       tx_rdy_out;
    logic       tx_done_in;
    logic [7:0] reg_addr_out;
    logic [7:0] reg_wdata_out;
    logic       reg_we_out;
    logic       reg_re_out;
    logic [7:0] reg_rdata_in;
    logic [7:0] err_count_out;
    logic       busy_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_rx_cyc = 0;
    int last_tx_cyc = 0;
    int tx_delay = 2;

    logic [23:0] exp_q[$];
    logic [7:0]  slave_mem[256];
    logic [7:0]  err_model;
    logic [7:0]  last_addr;
    logic [7:0]  last_wdata;
    logic        re_seen;

    uart_reg_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .nrst_in      (nrst_in),
        .rx_data_in   (rx_data_in),
        .rx_rdy_in    (rx_rdy_in),
        .tx_data_out  (tx_data_out),
        .tx_rdy_out   (tx_rdy_out),
        .tx_done_in   (tx_done_in),
        .reg_addr_out (reg_addr_out),
        .reg_wdata_out(reg_wdata_out),
        .reg_we_out   (reg_we_out),
        .reg_re_out   (reg_re_out),
        .reg_rdata_in (reg_rdata_in),
        .err_count_out(err_count_out),
        .busy_out     (busy_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data_in  = b;
        rx_rdy_in   = 1'b1;
        last_rx_cyc = cyc;
        @(posedge clk);
        #1;
        rx_rdy_in  = 1'b0;
        rx_data_in = 8'($urandom);
    endtask

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic randGap();
        repeat ($urandom_range(0, 4)) @(posedge clk);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!busy_out) break;
        end
        checkOutput("wait_idle", 32'(busy_out), 32'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        nrst_in = 1'b0;
        exp_q.delete();
        err_model  = 8'h00;
        last_addr  = 8'h00;
        last_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        nrst_in = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_err"},     32'(err_count_out), 32'd0);
        checkOutput({tag, "_busy"},    32'(busy_out), 32'd0);
        checkOutput({tag, "_txdata"},  32'(tx_data_out), 32'd0);
        checkOutput({tag, "_addr"},    32'(reg_addr_out), 32'd0);
        checkOutput({tag, "_wdata"},   32'(reg_wdata_out), 32'd0);
        checkOutput({tag, "_strobes"}, 32'({reg_we_out, reg_re_out, tx_rdy_out}), 32'd0);
    endtask

    task automatic writeFrame(input logic [7:0] addr, input logic [7:0] data);
        exp_q.push_back({KIND_WR, addr, data});
`ifdef BRIDGE_ACK_EN
        exp_q.push_back({KIND_TX, 8'h00, 8'h06});
`endif
        applyStimulus(8'h57);
        randGap();
        applyStimulus(addr);
        randGap();
        applyStimulus(data);
        last_addr  = addr;
        last_wdata = data;
        waitIdle();
    endtask

    task automatic readFrame(input logic [7:0] addr);
        exp_q.push_back({KIND_RD, addr, 8'h00});
        exp_q.push_back({KIND_TX, 8'h00, slave_mem[addr]});
        applyStimulus(8'h52);
        randGap();
        applyStimulus(addr);
        last_addr = addr;
        waitIdle();
    endtask

    task automatic popCheck(input string name, input logic [23:0] got);
        if (exp_q.size() == 0) begin
            checkOutput({name, "_unexpected"}, 32'(got), 32'hFFFFFFFF);
        end else begin
            checkOutput(name, 32'(got), 32'(exp_q.pop_front()));
        end
    endtask

    // Monitor: every strobe the DUT presents must match the next modelled event.
    always @(negedge clk) begin
        if (nrst_in) begin
            if (reg_we_out) popCheck("write_strobe", {KIND_WR, reg_addr_out, reg_wdata_out});
            if (reg_re_out) popCheck("read_strobe", {KIND_RD, reg_addr_out, 8'h00});
            if (tx_rdy_out) begin
                popCheck("tx_request", {KIND_TX, 8'h00, tx_data_out});
                last_tx_cyc = cyc;
            end
        end
    end

    // Register slave: read data is only meaningful the cycle after the read strobe.
    initial begin
        reg_rdata_in = 8'h00;
        forever begin
            @(negedge clk);
            re_seen = reg_re_out;
            @(posedge clk);
            #1;
            reg_rdata_in = re_seen ? slave_mem[reg_addr_out] : 8'($urandom);
        end
    end

    // Transmitter: finishes each requested byte after tx_delay cycles.
    initial begin
        logic [7:0] held;
        tx_done_in = 1'b0;
        forever begin
            @(negedge clk);
            if (nrst_in && tx_rdy_out) begin
                held = tx_data_out;
                repeat (tx_delay) @(posedge clk);
                #1;
                checkOutput("tx_data_stable", 32'(tx_data_out), 32'(held));
                tx_done_in = 1'b1;
                @(posedge clk);
                #1;
                tx_done_in = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        nrst_in    = 1'b0;
        rx_data_in = 8'h00;
        rx_rdy_in  = 1'b0;
        err_model  = 8'h00;
        last_addr  = 8'h00;
        last_wdata = 8'h00;
        for (int i = 0; i < 256; i++) slave_mem[i] = 8'($urandom);
        slave_mem[8'h22] = 8'h3C;

        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        nrst_in = 1'b1;

        $display("[TB] write frame 57 10 A5");
        writeFrame(8'h10, 8'hA5);
        checkOutput("write_addr_hold", 32'(reg_addr_out), 32'h10);
        checkOutput("write_wdata_hold", 32'(reg_wdata_out), 32'hA5);

        $display("[TB] read frame 52 22 with latency check");
        last_tx_cyc = 0;
        readFrame(8'h22);
        checkOutput("read_latency", 32'(last_tx_cyc - last_rx_cyc), 32'd4);
        checkOutput("read_tx_data", 32'(tx_data_out), 32'h3C);
        checkOutput("read_wdata_hold", 32'(reg_wdata_out), 32'hA5);

        $display("[TB] invalid opcodes and saturation");
        doReset();
        applyStimulus(8'h41);
        checkOutput("err_single", 32'(err_count_out), 32'd1);
        checkOutput("err_single_busy", 32'(busy_out), 32'd0);
        for (int i = 0; i < 299; i++) applyStimulus(8'h41);
        checkOutput("err_saturated", 32'(err_count_out), 32'hFF);

        $display("[TB] address timeout boundary");
        doReset();
        applyStimulus(8'h57);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("timeout_last_cycle_busy", 32'(busy_out), 32'd1);
        checkOutput("timeout_last_cycle_err", 32'(err_count_out), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("timeout_idle", 32'(busy_out), 32'd0);
        checkOutput("timeout_err", 32'(err_count_out), 32'd1);
        err_model = 8'd1;

        exp_q.push_back({KIND_WR, 8'h10, 8'h5E});
`ifdef BRIDGE_ACK_EN
        exp_q.push_back({KIND_TX, 8'h00, 8'h06});
`endif
        applyStimulus(8'h57);
        repeat (14) @(posedge clk);
        applyStimulus(8'h10);
        checkOutput("late_byte_busy", 32'(busy_out), 32'd1);
        checkOutput("late_byte_addr", 32'(reg_addr_out), 32'h10);
        checkOutput("late_byte_err", 32'(err_count_out), 32'(err_model));
        applyStimulus(8'h5E);
        waitIdle();

        $display("[TB] byte during WAIT_TX");
        tx_delay = 12;
        exp_q.push_back({KIND_RD, 8'h33, 8'h00});
        exp_q.push_back({KIND_TX, 8'h00, slave_mem[8'h33]});
        applyStimulus(8'h52);
        applyStimulus(8'h33);
        repeat (4) @(posedge clk);
        applyStimulus(8'h99);
        err_model = satInc(err_model);
        checkOutput("drop_err", 32'(err_count_out), 32'(err_model));
        checkOutput("drop_tx_data", 32'(tx_data_out), 32'(slave_mem[8'h33]));
        checkOutput("drop_still_busy", 32'(busy_out), 32'd1);
        waitIdle();
        tx_delay = 2;

        $display("[TB] reset during GET_DATA");
        applyStimulus(8'h57);
        applyStimulus(8'h44);
        nrst_in = 1'b0;
        #1;
        checkAllZero("midframe_reset");
        exp_q.delete();
        err_model = 8'h00;
        @(posedge clk);
        #1;
        nrst_in = 1'b1;
        writeFrame(8'h21, 8'h7E);
        checkOutput("post_reset_addr", 32'(reg_addr_out), 32'h21);

        $display("[TB] randomized frames");
        doReset();
        for (int n = 0; n < 60; n++) begin
            tx_delay = $urandom_range(1, 4);
            case ($urandom_range(0, 2))
                0: writeFrame(8'($urandom), 8'($urandom));
                1: readFrame(8'($urandom));
                default: begin
                    b = 8'($urandom);
                    while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
                    applyStimulus(b);
                    err_model = satInc(err_model);
                    waitIdle();
                end
            endcase
            checkOutput("rand_err", 32'(err_count_out), 32'(err_model));
            checkOutput("rand_addr_hold", 32'(reg_addr_out), 32'(last_addr));
            checkOutput("rand_wdata_hold", 32'(reg_wdata_out), 32'(last_wdata));
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
